// File: rtl/guess_pkg.sv
// Shared types and charset helpers for the guess sweep generator.
// Charset indices map to ASCII here so every consumer agrees on ordering.
package guess_pkg;

    typedef enum logic [2:0] {
        CsLower     = 3'd0,
        CsUpper     = 3'd1,
        CsLetters   = 3'd2,
        CsAlnum     = 3'd3,
        CsPrintable = 3'd4,
        CsByte      = 3'd5
    } charset_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    localparam logic [8:0] SizeLower     = 9'd26;
    localparam logic [8:0] SizeUpper     = 9'd26;
    localparam logic [8:0] SizeLetters   = 9'd52;
    localparam logic [8:0] SizeAlnum     = 9'd62;
    localparam logic [8:0] SizePrintable = 9'd94;
    localparam logic [8:0] SizeByte      = 9'd256;

    // Unknown charsets report size 0 so any offset check rejects them.
    function automatic logic [8:0] charset_size(input logic [2:0] cs);
        logic [8:0] sz;
        case (cs)
            CsLower:     sz = SizeLower;
            CsUpper:     sz = SizeUpper;
            CsLetters:   sz = SizeLetters;
            CsAlnum:     sz = SizeAlnum;
            CsPrintable: sz = SizePrintable;
            CsByte:      sz = SizeByte;
            default:     sz = 9'd0;
        endcase
        return sz;
    endfunction

    function automatic logic [7:0] charset_char(input logic [2:0] cs, input logic [8:0] idx);
        logic [8:0] c;
        case (cs)
            CsLower:     c = 9'h61 + idx;
            CsUpper:     c = 9'h41 + idx;
            CsLetters:   c = (idx < 9'd26) ? 9'h61 + idx : 9'h41 + idx - 9'd26;
            CsAlnum: begin
                if (idx < 9'd26)      c = 9'h61 + idx;
                else if (idx < 9'd52) c = 9'h41 + idx - 9'd26;
                else                  c = 9'h30 + idx - 9'd52;
            end
            CsPrintable: c = 9'h21 + idx;
            default:     c = idx;
        endcase
        return c[7:0];
    endfunction

endpackage

// File: rtl/guess_sweep_generator_if.sv
// Guess stream toward the hash pipeline: valid/ready handshake plus payload.
interface guess_sweep_generator_if #(
    parameter int MAX_LEN = 16
);
    logic [MAX_LEN*8-1:0] guess;
    logic [4:0]           guess_len;
    logic                 guess_valid;
    logic                 guess_ready;
    logic                 guess_last;

    modport master (
        output guess,
        output guess_len,
        output guess_valid,
        output guess_last,
        input  guess_ready
    );

    modport slave (
        input  guess,
        input  guess_len,
        input  guess_valid,
        input  guess_last,
        output guess_ready
    );
endinterface

// File: rtl/guess_digit_counter.sv
// Mixed-radix digit register: digit 0 steps by stride, higher digits count by one.
// wrap flags that the next advance carries out of the top active digit.
module guess_digit_counter #(
    parameter int MAX_LEN = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic                     advance,
    input  logic [7:0]               offset,
    input  logic [8:0]               stride,
    input  logic [8:0]               size,
    input  logic [4:0]               len,
    output logic [MAX_LEN-1:0][8:0]  digits,
    output logic                     wrap
);

    logic [MAX_LEN-1:0][8:0] digits_nxt;
    logic [9:0]              sum;
    logic                    carry;

    always_comb begin
        digits_nxt = digits;
        sum        = {1'b0, digits[0]} + {1'b0, stride};
        carry      = (sum >= {1'b0, size});
        digits_nxt[0] = carry ? 9'(sum - {1'b0, size}) : sum[8:0];
        wrap       = (len == 5'd1) && carry;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (5'(i) < len) begin
                if (carry) begin
                    digits_nxt[i] = (digits[i] == size - 9'd1) ? 9'd0 : digits[i] + 9'd1;
                end
                carry = carry && (digits[i] == size - 9'd1);
                if (5'(i) == len - 5'd1) wrap = carry;
            end else begin
                digits_nxt[i] = 9'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            digits <= '0;
        end else if (load) begin
            digits <= {{((MAX_LEN - 1) * 9){1'b0}}, 1'b0, offset};
        end else if (advance) begin
            digits <= digits_nxt;
        end
    end

endmodule

// File: rtl/guess_sweep_generator.sv
// Enumerates all guesses over a charset for lengths len_min..len_max, with
// offset/stride interleaving on digit 0 so several cores can split a keyspace.
module guess_sweep_generator
    import guess_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 48
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [2:0]              charset,
    input  logic [4:0]              len_min,
    input  logic [4:0]              len_max,
    input  logic [7:0]              offset,
    input  logic [8:0]              stride,
    guess_sweep_generator_if.master gif,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [CNT_W-1:0]        guess_count
);

    state_e           state_q, state_d;
    logic [2:0]       cs_q, cs_d;
    logic [4:0]       len_q, len_d;
    logic [4:0]       len_max_q, len_max_d;
    logic [7:0]       offset_q, offset_d;
    logic [8:0]       stride_q, stride_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic [MAX_LEN-1:0][8:0] digits;
    logic                    wrap;
    logic                    ctr_load, ctr_advance;
    logic [7:0]              ctr_offset;
    logic [8:0]              size_q, size_in;
    logic                    reject, accept;
    logic [MAX_LEN*8-1:0]    guess_w;

    assign size_in = charset_size(charset);
    assign size_q  = charset_size(cs_q);
    assign reject  = (charset > 3'd5) || (len_min == 5'd0) || (len_min > len_max) ||
                     (len_max > 5'(MAX_LEN)) || ({1'b0, offset} >= size_in) ||
                     (stride == 9'd0) || (stride > size_in);
    assign accept  = (state_q == StRun) && gif.guess_ready;

    guess_digit_counter #(
        .MAX_LEN (MAX_LEN)
    ) u_digits (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (ctr_load),
        .advance (ctr_advance),
        .offset  (ctr_offset),
        .stride  (stride_q),
        .size    (size_q),
        .len     (len_q),
        .digits  (digits),
        .wrap    (wrap)
    );

    always_comb begin
        state_d     = state_q;
        cs_d        = cs_q;
        len_d       = len_q;
        len_max_d   = len_max_q;
        offset_d    = offset_q;
        stride_d    = stride_q;
        count_d     = count_q;
        done_d      = done_q;
        error_d     = error_q;
        ctr_load    = 1'b0;
        ctr_advance = 1'b0;
        ctr_offset  = offset_q;

        // start wins over any handshake in flight, aborting the running job
        if (start) begin
            count_d = '0;
            if (reject) begin
                state_d = StFin;
                error_d = 1'b1;
                done_d  = 1'b1;
            end else begin
                state_d    = StRun;
                cs_d       = charset;
                len_d      = len_min;
                len_max_d  = len_max;
                offset_d   = offset;
                stride_d   = stride;
                error_d    = 1'b0;
                done_d     = 1'b0;
                ctr_load   = 1'b1;
                ctr_offset = offset;
            end
        end else if (accept) begin
            if (~&count_q) count_d = count_q + 1'b1;
            if (!wrap) begin
                ctr_advance = 1'b1;
            end else if (len_q < len_max_q) begin
                len_d    = len_q + 5'd1;
                ctr_load = 1'b1;
            end else begin
                state_d = StFin;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cs_q      <= 3'd0;
            len_q     <= 5'd0;
            len_max_q <= 5'd0;
            offset_q  <= 8'd0;
            stride_q  <= 9'd0;
            count_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            len_q     <= len_d;
            len_max_q <= len_max_d;
            offset_q  <= offset_d;
            stride_q  <= stride_d;
            count_q   <= count_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // char 0 sits in the MSBs; inactive positions read as 0x00
    always_comb begin
        guess_w = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (5'(i) < len_q) guess_w[(MAX_LEN-1-i)*8 +: 8] = charset_char(cs_q, digits[i]);
        end
    end

    assign gif.guess       = guess_w;
    assign gif.guess_len   = len_q;
    assign gif.guess_valid = (state_q == StRun);
    assign gif.guess_last  = (state_q == StRun) && wrap && (len_q == len_max_q);
    assign busy            = (state_q == StRun);
    assign done            = done_q;
    assign error           = error_q;
    assign guess_count     = count_q;

endmodule
